calculadora_secuencial: RTL



---
 rtl/calculadora_secuencial_if.sv | 28 ++
 rtl/calculadora_secuencial.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calculadora_secuencial_if.sv
// Operand/result bus of the sequential calculator.
// The master drives the operands and the start request; the slave returns
// the handshake, the registered result and the status flags.
interface calculadora_secuencial_if #(
  parameter int WIDTH = 5
) ();
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [2:0]         sel;
  logic               start;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic [2:0]         cmp;
  logic               zero;
  logic               neg;
  logic               err;

  modport master (
    output a, b, sel, start,
    input  busy, done, result, cmp, zero, neg, err
  );

  modport slave (
    input  a, b, sel, start,
    output busy, done, result, cmp, zero, neg, err
  );
endinterface

// File: rtl/calculadora_secuencial.sv
// Registered calculator: one-cycle ALU ops plus sequential shift-add multiply
// and restoring divide behind a start/busy/done handshake. A free-running
// scanner shows the registered result in hex on a multiplexed 7-seg display.
module calculadora_secuencial #(
  parameter int WIDTH       = 5,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 200000
) (
  input  logic                   CLK_100MHz,
  input  logic                   RST_n,
  calculadora_secuencial_if.slave bus,
  output logic [6:0]             SevenSegment,
  output logic [DIGITS-1:0]      SevenSegmentEnable
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (4 * DIGITS > RW) ? 4 * DIGITS : RW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_NEGA = 3'b011;
  localparam logic [2:0] OP_NEGB = 3'b100;
  localparam logic [2:0] OP_CAT  = 3'b101;
  localparam logic [2:0] OP_CMP  = 3'b110;
  localparam logic [2:0] OP_DIV  = 3'b111;

  // Sign-extend a WIDTH+1 bit two's complement value to the result width.
  function automatic logic [RW-1:0] sext(input logic [WIDTH:0] v);
    return {{(WIDTH-1){v[WIDTH]}}, v};
  endfunction

  // Hex nibble to active-low segments {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    acc_q, acc_d, mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [RW-1:0]    result_q, result_d;
  logic [2:0]       cmp_q, cmp_d;
  logic             zero_q, zero_d, neg_q, neg_d, err_q, err_d;

  logic [DW-1:0]     div_q, div_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] en_q, en_d;

  logic [WIDTH:0]   sum_s, diff_s, nega_s, negb_s, rem_sh_s;
  logic [2:0]       cmp_val_s;
  logic [RW-1:0]    fin_res_s;
  logic             fin_neg_s, fin_err_s;
  logic [2:0]       fin_cmp_s;
  logic [PW-1:0]    pad_s;
  logic [3:0]       nib_s;

  assign sum_s     = {1'b0, a_q} + {1'b0, b_q};
  assign diff_s    = {1'b0, a_q} - {1'b0, b_q};
  assign nega_s    = {(WIDTH+1){1'b0}} - {1'b0, a_q};
  assign negb_s    = {(WIDTH+1){1'b0}} - {1'b0, b_q};
  assign cmp_val_s = {a_q > b_q, a_q == b_q, a_q < b_q};
  // Partial remainder shifted left with the next dividend bit brought in.
  assign rem_sh_s  = {rem_q, quo_q[WIDTH-1]};

  // Final result and flags of the latched operation, valid on its completion cycle.
  always_comb begin
    fin_res_s = {RW{1'b0}};
    fin_neg_s = 1'b0;
    fin_err_s = 1'b0;
    fin_cmp_s = cmp_q;
    case (sel_q)
      OP_ADD:  fin_res_s = {{(WIDTH-1){1'b0}}, sum_s};
      OP_SUB: begin
        fin_res_s = sext(diff_s);
        fin_neg_s = (a_q < b_q);
      end
      OP_MUL:  fin_res_s = acc_q;
      OP_NEGA: begin
        fin_res_s = sext(nega_s);
        fin_neg_s = (a_q != {WIDTH{1'b0}});
      end
      OP_NEGB: begin
        fin_res_s = sext(negb_s);
        fin_neg_s = (b_q != {WIDTH{1'b0}});
      end
      OP_CAT:  fin_res_s = {a_q, b_q};
      OP_CMP: begin
        fin_cmp_s = cmp_val_s;
        fin_res_s = {{(RW-3){1'b0}}, cmp_val_s};
      end
      OP_DIV: begin
        if (b_q == {WIDTH{1'b0}}) begin
          fin_res_s = {RW{1'b1}};
          fin_err_s = 1'b1;
        end else begin
          fin_res_s = {rem_q, quo_q};
        end
      end
      default: fin_res_s = {RW{1'b0}};
    endcase
  end

  // Handshake FSM plus multiply/divide iteration; divide by zero still runs all iterations.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    cmp_d    = cmp_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          sel_d    = bus.sel;
          busy_d   = 1'b1;
          cnt_d    = {CW{1'b0}};
          acc_d    = {RW{1'b0}};
          mcand_d  = {{WIDTH{1'b0}}, bus.a};
          mplier_d = bus.b;
          rem_d    = {WIDTH{1'b0}};
          quo_d    = bus.a;
          if ((bus.sel == OP_MUL) || (bus.sel == OP_DIV)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        result_d = fin_res_s;
        zero_d   = (fin_res_s == {RW{1'b0}});
        neg_d    = fin_neg_s;
        err_d    = fin_err_s;
        cmp_d    = fin_cmp_s;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      ST_RUN: begin
        if (cnt_q != CW'(WIDTH)) begin
          cnt_d = cnt_q + CW'(1'b1);
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end else begin
            acc_d = acc_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (rem_sh_s >= {1'b0, b_q}) begin
            rem_d = rem_sh_s[WIDTH-1:0] - b_q;
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_d = rem_sh_s[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          result_d = fin_res_s;
          zero_d   = (fin_res_s == {RW{1'b0}});
          neg_d    = fin_neg_s;
          err_d    = fin_err_s;
          cmp_d    = fin_cmp_s;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Calculator state, datapath and status registers.
  always_ff @(posedge CLK_100MHz or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= ST_IDLE;
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      sel_q    <= 3'b000;
      cnt_q    <= {CW{1'b0}};
      acc_q    <= {RW{1'b0}};
      mcand_q  <= {RW{1'b0}};
      mplier_q <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      quo_q    <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {RW{1'b0}};
      cmp_q    <= 3'b000;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cmp_q    <= cmp_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  // Refresh divider, digit index and the nibble of the result for the next digit.
  always_comb begin
    pad_s = {PW{1'b0}};
    pad_s[RW-1:0] = result_q;
    if (div_q == DW'(REFRESH_DIV - 1)) begin
      div_d = {DW{1'b0}};
      if (idx_q == IW'(DIGITS - 1)) begin
        idx_d = {IW{1'b0}};
      end else begin
        idx_d = idx_q + IW'(1'b1);
      end
    end else begin
      div_d = div_q + DW'(1'b1);
      idx_d = idx_q;
    end
    nib_s = pad_s[{idx_d, 2'b00} +: 4];
    seg_d = hex7(nib_s);
    en_d  = ~(DIGITS'(1'b1) << idx_d);
  end

  // Display scan registers; enable and segments move together.
  always_ff @(posedge CLK_100MHz or negedge RST_n) begin
    if (!RST_n) begin
      div_q <= {DW{1'b0}};
      idx_q <= {IW{1'b0}};
      seg_q <= 7'h40;
      en_q  <= ~DIGITS'(1'b1);
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      seg_q <= seg_d;
      en_q  <= en_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.result         = result_q;
  assign bus.cmp            = cmp_q;
  assign bus.zero           = zero_q;
  assign bus.neg            = neg_q;
  assign bus.err            = err_q;
  assign SevenSegment       = seg_q;
  assign SevenSegmentEnable = en_q;

endmodule
